// File: rtl/dunit_pipe_ctrl.sv
// Debug-unit execution controller: gates the pipeline clock-enable for run/step,
// drains the pipeline after HALT and sequences a state dump toward the UART TX path.
module dunit_pipe_ctrl #(
    parameter int unsigned NB_DRAIN     = 4,
    parameter int unsigned NB_CNT       = 3,
    parameter int unsigned N_DUMP_WORDS = 32,
    parameter int unsigned NB_IDX       = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_halt,
    output logic              o_dunit_clk_en,
    output logic              o_pipe_flush,
    output logic              o_dump_valid,
    output logic [NB_IDX-1:0] o_dump_idx,
    input  logic              i_dump_ready,
    output logic              o_done,
    output logic              o_halted,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StStep  = 3'd2,
        StDrain = 3'd3,
        StDump  = 3'd4
    } state_t;

    localparam logic [1:0] CmdRun   = 2'b00;
    localparam logic [1:0] CmdStep  = 2'b01;
    localparam logic [1:0] CmdDump  = 2'b10;
    localparam logic [1:0] CmdFlush = 2'b11;

    localparam logic [NB_CNT-1:0] DrainLoad = NB_CNT'(NB_DRAIN - 1);
    localparam logic [NB_IDX-1:0] LastIdx   = NB_IDX'(N_DUMP_WORDS - 1);

    state_t              state_q;
    logic [NB_CNT-1:0]   cnt_q;
    logic [NB_IDX-1:0]   idx_q;
    logic                clk_en_q;
    logic                flush_q;
    logic                dump_valid_q;
    logic                done_q;
    logic                halted_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            clk_en_q     <= 1'b0;
            flush_q      <= 1'b0;
            dump_valid_q <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            flush_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_cmd_valid) begin
                        unique case (i_cmd)
                            CmdRun, CmdStep: begin
                                // A halted program cannot resume until flushed
                                if (halted_q) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q  <= (i_cmd == CmdRun) ? StRun : StStep;
                                    clk_en_q <= 1'b1;
                                end
                            end
                            CmdDump: begin
                                state_q      <= StDump;
                                dump_valid_q <= 1'b1;
                                idx_q        <= '0;
                            end
                            CmdFlush: begin
                                flush_q  <= 1'b1;
                                halted_q <= 1'b0;
                                done_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                StRun: begin
                    if (i_halt && clk_en_q) begin
                        state_q <= StDrain;
                        cnt_q   <= DrainLoad;
                    end
                end
                StStep: begin
                    if (i_halt && clk_en_q) begin
                        state_q <= StDrain;
                        cnt_q   <= DrainLoad;
                    end else begin
                        state_q  <= StIdle;
                        clk_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                StDrain: begin
                    if (cnt_q == '0) begin
                        state_q  <= StIdle;
                        clk_en_q <= 1'b0;
                        halted_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDump: begin
                    if (i_dump_ready) begin
                        if (idx_q == LastIdx) begin
                            state_q      <= StIdle;
                            dump_valid_q <= 1'b0;
                            idx_q        <= '0;
                            done_q       <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    clk_en_q     <= 1'b0;
                    dump_valid_q <= 1'b0;
                    idx_q        <= '0;
                end
            endcase
        end
    end

    assign o_cmd_ready    = (state_q == StIdle);
    assign o_dunit_clk_en = clk_en_q;
    assign o_pipe_flush   = flush_q;
    assign o_dump_valid   = dump_valid_q;
    assign o_dump_idx     = idx_q;
    assign o_done         = done_q;
    assign o_halted       = halted_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_dunit_pipe_ctrl.sv
// Directed bench for dunit_pipe_ctrl: step, run/halt/drain, halted no-ops, flush,
// dump handshake with back-pressure and mid-operation reset.
module tb_dunit_pipe_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_cmd_valid;
    logic [1:0] i_cmd;
    logic       o_cmd_ready;
    logic       i_halt;
    logic       o_dunit_clk_en;
    logic       o_pipe_flush;
    logic       o_dump_valid;
    logic [4:0] o_dump_idx;
    logic       i_dump_ready;
    logic       o_done;
    logic       o_halted;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] CRun = 2'b00, CStep = 2'b01, CDump = 2'b10, CFlush = 2'b11;

    dunit_pipe_ctrl dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .o_cmd_ready    (o_cmd_ready),
        .i_halt         (i_halt),
        .o_dunit_clk_en (o_dunit_clk_en),
        .o_pipe_flush   (o_pipe_flush),
        .o_dump_valid   (o_dump_valid),
        .o_dump_idx     (o_dump_idx),
        .i_dump_ready   (i_dump_ready),
        .o_done         (o_done),
        .o_halted       (o_halted),
        .o_state        (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Packed view: {state, cmd_ready, clk_en, flush, dump_valid, idx, done, halted}
    logic [13:0] obs;
    assign obs = {o_state, o_cmd_ready, o_dunit_clk_en, o_pipe_flush, o_dump_valid,
                  o_dump_idx, o_done, o_halted};
    localparam logic [13:0] ResetObs = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] cmd);
        i_cmd_valid = 1'b1;
        i_cmd       = cmd;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        checks++;
        if (obs !== ResetObs) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", obs, ResetObs);
        end
    endtask

    task automatic test_step();
        for (int n = 0; n < 3; n++) begin
            issue(CStep);
            checks++;
            if ({o_state, o_dunit_clk_en, o_done} !== {3'd2, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL step_enabled[%0d]: got %b expected %b", n,
                         {o_state, o_dunit_clk_en, o_done}, {3'd2, 1'b1, 1'b0});
            end
            tick();
            checks++;
            if ({o_state, o_dunit_clk_en, o_done, o_halted} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL step_done[%0d]: got %b expected %b", n,
                         {o_state, o_dunit_clk_en, o_done, o_halted}, {3'd0, 1'b0, 1'b1, 1'b0});
            end
            tick();
            checks++;
            if ({o_dunit_clk_en, o_done} !== 2'b00) begin
                errors++;
                $display("FAIL step_gap[%0d]: got %b expected 00", n, {o_dunit_clk_en, o_done});
            end
        end
    endtask

    // Expects to be in the first DRAIN cycle; checks NB_DRAIN enabled cycles then the exit.
    task automatic check_drain(input string tag);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({o_state, o_dunit_clk_en, o_done} !== {3'd3, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s_drain[%0d]: got %b expected %b", tag, d,
                         {o_state, o_dunit_clk_en, o_done}, {3'd3, 1'b1, 1'b0});
            end
            tick();
        end
        checks++;
        if ({o_state, o_dunit_clk_en, o_done, o_halted} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL %s_drain_exit: got %b expected %b", tag,
                     {o_state, o_dunit_clk_en, o_done, o_halted}, {3'd0, 1'b0, 1'b1, 1'b1});
        end
        tick();
        checks++;
        if ({o_done, o_dunit_clk_en} !== 2'b00) begin
            errors++;
            $display("FAIL %s_done_single: got %b expected 00", tag, {o_done, o_dunit_clk_en});
        end
    endtask

    task automatic test_run_halt();
        issue(CRun);
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if ({o_state, o_dunit_clk_en, o_cmd_ready} !== {3'd1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL run_cycle[%0d]: got %b expected %b", c,
                         {o_state, o_dunit_clk_en, o_cmd_ready}, {3'd1, 1'b1, 1'b0});
            end
            // A pending DUMP must be ignored while running
            i_cmd_valid = (c < 10);
            i_cmd       = CDump;
            i_halt      = (c == 10);
            tick();
            i_halt      = 1'b0;
            i_cmd_valid = 1'b0;
        end
        check_drain("run");
    endtask

    task automatic test_halted_noop();
        issue(CRun);
        checks++;
        if ({o_state, o_dunit_clk_en, o_done, o_halted} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL halted_run_noop: got %b expected %b",
                     {o_state, o_dunit_clk_en, o_done, o_halted}, {3'd0, 1'b0, 1'b1, 1'b1});
        end
        issue(CStep);
        checks++;
        if ({o_state, o_dunit_clk_en, o_done, o_halted} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL halted_step_noop: got %b expected %b",
                     {o_state, o_dunit_clk_en, o_done, o_halted}, {3'd0, 1'b0, 1'b1, 1'b1});
        end
        tick();
        issue(CFlush);
        checks++;
        if ({o_state, o_pipe_flush, o_done, o_halted} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL flush_pulse: got %b expected %b",
                     {o_state, o_pipe_flush, o_done, o_halted}, {3'd0, 1'b1, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if ({o_pipe_flush, o_done, o_halted} !== 3'b000) begin
            errors++;
            $display("FAIL flush_end: got %b expected 000", {o_pipe_flush, o_done, o_halted});
        end
    endtask

    task automatic test_dump();
        int  exp_idx = 0;
        int  p       = 0;
        bit  fin     = 0;
        issue(CDump);
        while (!fin && p < 200) begin
            checks++;
            if ({o_state, o_dump_valid, o_dump_idx, o_dunit_clk_en, o_done} !==
                {3'd4, 1'b1, 5'(exp_idx), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL dump_word[%0d]: got %b expected %b", p,
                         {o_state, o_dump_valid, o_dump_idx, o_dunit_clk_en, o_done},
                         {3'd4, 1'b1, 5'(exp_idx), 1'b0, 1'b0});
            end
            i_dump_ready = (p % 3 == 0);
            tick();
            if (i_dump_ready) begin
                if (exp_idx == 31) fin = 1;
                else exp_idx++;
            end
            i_dump_ready = 1'b0;
            p++;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL dump_timeout: got idx %0d expected 31", exp_idx);
        end
        checks++;
        if ({o_state, o_dump_valid, o_dump_idx, o_done, o_halted} !==
            {3'd0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dump_done: got %b expected %b",
                     {o_state, o_dump_valid, o_dump_idx, o_done, o_halted},
                     {3'd0, 1'b0, 5'd0, 1'b1, 1'b0});
        end
        tick();
    endtask

    task automatic test_step_halt();
        issue(CStep);
        checks++;
        if ({o_state, o_dunit_clk_en} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL step_halt_enabled: got %b expected %b",
                     {o_state, o_dunit_clk_en}, {3'd2, 1'b1});
        end
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        check_drain("step");
        issue(CFlush);
        tick();
    endtask

    task automatic test_reset_mid();
        issue(CDump);
        i_dump_ready = 1'b1;
        repeat (7) tick();
        i_dump_ready = 1'b0;
        checks++;
        if ({o_state, o_dump_idx} !== {3'd4, 5'd7}) begin
            errors++;
            $display("FAIL dump_reach_idx7: got %b expected %b", {o_state, o_dump_idx},
                     {3'd4, 5'd7});
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checks++;
        if (obs !== ResetObs) begin
            errors++;
            $display("FAIL reset_mid_dump: got %b expected %b", obs, ResetObs);
        end
        issue(CRun);
        tick();
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        tick();
        checks++;
        if ({o_state, o_dunit_clk_en} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL reach_drain: got %b expected %b", {o_state, o_dunit_clk_en},
                     {3'd3, 1'b1});
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checks++;
        if (obs !== ResetObs) begin
            errors++;
            $display("FAIL reset_mid_drain: got %b expected %b", obs, ResetObs);
        end
        tick();
        checks++;
        if (obs !== ResetObs) begin
            errors++;
            $display("FAIL reset_mid_drain_after: got %b expected %b", obs, ResetObs);
        end
    endtask

    initial begin
        i_reset      = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd        = 2'b00;
        i_halt       = 1'b0;
        i_dump_ready = 1'b0;
        test_reset();
        test_step();
        test_run_halt();
        test_halted_noop();
        test_dump();
        test_step_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
